// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake, FIFO status and serial line of the buffered UART transmitter.
interface uart_tx_fifo_if;
    logic       wr_en_in;
    logic [7:0] wr_data_in;
    logic       full_out;
    logic       empty_out;
    logic       busy_out;
    logic       overflow_out;
    logic       tx_out;

    modport master (
        output wr_en_in,
        output wr_data_in,
        input  full_out,
        input  empty_out,
        input  busy_out,
        input  overflow_out,
        input  tx_out
    );

    modport slave (
        input  wr_en_in,
        input  wr_data_in,
        output full_out,
        output empty_out,
        output busy_out,
        output overflow_out,
        output tx_out
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes are queued in a circular FIFO and sent as
// start / 8 data (LSB first) / optional parity / stop bits, back-to-back
// while the FIFO holds data. The line is registered from the current state,
// so it trails the FSM by one clock while keeping every bit exactly
// CLKS_PER_BIT clocks long.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT    = 868,
    parameter int unsigned PARITY          = 0,
    parameter int unsigned STOP_BITS       = 1,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input logic           clk_in,
    input logic           reset_in,
    uart_tx_fifo_if.slave bus
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [TW-1:0]              T_LAST    = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]                 STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_FULL  = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q;
    logic [FIFO_DEPTH_LOG2:0]   count_q;
    logic [FIFO_DEPTH_LOG2:0]   count_d;
    logic                       full_q;
    logic                       empty_q;
    logic                       ovf_q;
    logic                       wr_acc;
    logic                       pop;
    logic [7:0]                 head;

    // Transmit FSM
    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            bit_done;

    // A write is accepted purely on the pre-edge full flag, so a same-edge pop never rescues a full FIFO
    assign wr_acc = bus.wr_en_in && !full_q;
    assign head   = mem[rd_ptr_q];

    // Next FIFO occupancy from the accepted write and the FSM pop
    always_comb begin
        count_d = count_q;
        if (wr_acc && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_acc && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO storage write; contents need no reset since the pointers define validity
    always_ff @(posedge clk_in) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= bus.wr_data_in;
        end
    end

    // FIFO pointers, occupancy, registered status flags and sticky overflow
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (bus.wr_en_in && full_q) begin
                ovf_q <= 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

    // Next-state logic: bit timing, bit index, shift register and FIFO pop
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        pop      = 1'b0;
        bit_done = (timer_q == T_LAST);

        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                    timer_d = '0;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    timer_d = '0;
                    bit_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    timer_d = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    timer_d = '0;
                    bit_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    timer_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next frame so no idle gap appears on the line
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                bit_d   = '0;
            end
        endcase

        if (pop) begin
            shift_d = head;
            par_d   = (PARITY == 1) ? ~^head : ^head;
        end
    end

    // Line level for the state currently being transmitted
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    // FSM and line registers; reset aborts any frame and forces the line high
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign bus.full_out     = full_q;
    assign bus.empty_out    = empty_q;
    assign bus.busy_out     = (state_q != ST_IDLE);
    assign bus.overflow_out = ovf_q;
    assign bus.tx_out       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parameterisations run side by side; a
// frame-level model (byte queue plus pop times) predicts the line and status
// outputs after every clock edge, and a bench receiver decodes the default
// instance's serial stream.
module tb_uart_tx_fifo;

    localparam int unsigned A_CPB = 868;
    localparam int unsigned B_CPB = 4;
    localparam int unsigned C_CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [3];
    logic       en    [3];
    logic [7:0] dat   [3];
    logic       tx_o  [3];
    logic       full_o[3];
    logic       empty_o[3];
    logic       busy_o[3];
    logic       ovf_o [3];

    uart_tx_fifo_if bus_a ();
    uart_tx_fifo_if bus_b ();
    uart_tx_fifo_if bus_c ();

    assign bus_a.wr_en_in = en[0];
    assign bus_a.wr_data_in = dat[0];
    assign bus_b.wr_en_in = en[1];
    assign bus_b.wr_data_in = dat[1];
    assign bus_c.wr_en_in = en[2];
    assign bus_c.wr_data_in = dat[2];

    assign tx_o[0] = bus_a.tx_out;
    assign tx_o[1] = bus_b.tx_out;
    assign tx_o[2] = bus_c.tx_out;
    assign full_o[0] = bus_a.full_out;
    assign full_o[1] = bus_b.full_out;
    assign full_o[2] = bus_c.full_out;
    assign empty_o[0] = bus_a.empty_out;
    assign empty_o[1] = bus_b.empty_out;
    assign empty_o[2] = bus_c.empty_out;
    assign busy_o[0] = bus_a.busy_out;
    assign busy_o[1] = bus_b.busy_out;
    assign busy_o[2] = bus_c.busy_out;
    assign ovf_o[0] = bus_a.overflow_out;
    assign ovf_o[1] = bus_b.overflow_out;
    assign ovf_o[2] = bus_c.overflow_out;

    uart_tx_fifo #(.CLKS_PER_BIT(A_CPB), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH_LOG2(4))
        dut_a (.clk_in(clk), .reset_in(rst[0]), .bus(bus_a));
    uart_tx_fifo #(.CLKS_PER_BIT(B_CPB), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH_LOG2(4))
        dut_b (.clk_in(clk), .reset_in(rst[1]), .bus(bus_b));
    uart_tx_fifo #(.CLKS_PER_BIT(C_CPB), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH_LOG2(2))
        dut_c (.clk_in(clk), .reset_in(rst[2]), .bus(bus_c));

    int p_cpb  [3] = '{868, 4, 4};
    int p_par  [3] = '{0, 2, 1};
    int p_stop [3] = '{1, 2, 2};
    int p_depth[3] = '{16, 16, 4};

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    longint      cyc     = 0;

    // Model: queued bytes, sticky overflow, edges of the two most recent pops
    logic [7:0] mq [3][$];
    bit         m_ovf [3];
    longint     m_last[3];
    longint     m_prev[3];
    logic [7:0] m_lb  [3];
    logic [7:0] m_pb  [3];

    logic [7:0] rxq[$];

    function automatic int frame_len(input int d);
        return (9 + ((p_par[d] != 0) ? 1 : 0) + p_stop[d]) * p_cpb[d];
    endfunction

    // Level of bit slot j within a frame carrying byte b
    function automatic logic line_bit(input int d, input logic [7:0] b, input int j);
        int ones;
        ones = 0;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (p_par[d] != 0 && j == 9) begin
            for (int i = 0; i < 8; i++) ones += int'(b[i]);
            if (p_par[d] == 2) return logic'(ones % 2);
            return logic'(1 - ones % 2);
        end
        return 1'b1;
    endfunction

    function automatic logic exp_tx(input int d);
        longint fl;
        fl = longint'(frame_len(d));
        if (m_last[d] < cyc && cyc <= m_last[d] + fl)
            return line_bit(d, m_lb[d], int'((cyc - m_last[d] - 1) / longint'(p_cpb[d])));
        if (m_prev[d] < cyc && cyc <= m_prev[d] + fl)
            return line_bit(d, m_pb[d], int'((cyc - m_prev[d] - 1) / longint'(p_cpb[d])));
        return 1'b1;
    endfunction

    function automatic bit all_idle();
        for (int d = 0; d < 3; d++) begin
            if (mq[d].size() != 0) return 1'b0;
            if (cyc - m_last[d] < longint'(frame_len(d))) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input int d);
        bit pop;
        bit acc;
        if (rst[d]) begin
            mq[d].delete();
            m_ovf[d]  = 1'b0;
            m_last[d] = -1000000;
            m_prev[d] = -1000000;
        end else begin
            pop = (mq[d].size() > 0) && (cyc - m_last[d] >= longint'(frame_len(d)));
            acc = (en[d] === 1'b1) && (mq[d].size() < p_depth[d]);
            if (en[d] === 1'b1 && !acc) m_ovf[d] = 1'b1;
            if (pop) begin
                m_prev[d] = m_last[d];
                m_pb[d]   = m_lb[d];
                m_last[d] = cyc;
                m_lb[d]   = mq[d].pop_front();
            end
            if (acc) mq[d].push_back(dat[d]);
        end
    endtask

    task automatic check(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, d, cyc, obs, exp);
    endtask

    task automatic check_outputs(input int d);
        check("tx", d, {7'd0, tx_o[d]}, {7'd0, exp_tx(d)});
        check("full", d, {7'd0, full_o[d]}, {7'd0, mq[d].size() == p_depth[d]});
        check("empty", d, {7'd0, empty_o[d]}, {7'd0, mq[d].size() == 0});
        check("busy", d, {7'd0, busy_o[d]}, {7'd0, (cyc - m_last[d]) < longint'(frame_len(d))});
        check("overflow", d, {7'd0, ovf_o[d]}, {7'd0, m_ovf[d]});
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 3; d++) model_edge(d);
        #1;
        for (int d = 0; d < 3; d++) check_outputs(d);
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (!all_idle() && g < 40000) begin
            tick();
            g++;
        end
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            check({tag, "_idle_busy"}, d, {7'd0, busy_o[d]}, 8'd0);
            check({tag, "_idle_empty"}, d, {7'd0, empty_o[d]}, 8'd1);
        end
    endtask

    // Bench receiver on the default instance: detect start, sample mid-bit
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst[0] === 1'b0 && tx_o[0] === 1'b0) begin
                repeat (A_CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (A_CPB) @(negedge clk);
                    b[i] = tx_o[0];
                end
                repeat (A_CPB) @(negedge clk);
                rxq.push_back(b);
            end
        end
    end

    initial begin
        longint n0;
        int seq_even[12] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
        int seq_odd [12] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        logic [7:0] exp_rx[6] = '{8'h55, 8'hA3, 8'h0F, 8'h00, 8'hFF, 8'h5A};
        logic [7:0] got;

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            en[d]  = 1'b0;
            dat[d] = 'x;
        end
        repeat (3) tick();
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        tick();

        // Single byte on the default instance: start bit two edges after the write
        en[0] = 1'b1; dat[0] = 8'h55;
        tick();
        en[0] = 1'b0; dat[0] = 'x;
        tick();
        check("t1_line_before_start", 0, {7'd0, tx_o[0]}, 8'd1);
        check("t1_busy_at_pop", 0, {7'd0, busy_o[0]}, 8'd1);
        tick();
        check("t1_start_latency", 0, {7'd0, tx_o[0]}, 8'd0);
        drain("t1");

        // Two bytes on consecutive clocks: chained frames
        en[0] = 1'b1; dat[0] = 8'hA3;
        tick();
        dat[0] = 8'h0F;
        tick();
        en[0] = 1'b0; dat[0] = 'x;
        drain("t2");

        // Burst of 18 writes: first byte pops at once, 0x00..0x10 fit, 0x11 is dropped
        for (int i = 0; i < 18; i++) begin
            en[1] = 1'b1; dat[1] = 8'(i);
            tick();
        end
        en[1] = 1'b0; dat[1] = 'x;
        check("t3_full", 1, {7'd0, full_o[1]}, 8'd1);
        check("t3_overflow", 1, {7'd0, ovf_o[1]}, 8'd1);
        drain("t3");

        // 0x07 with even parity (dut_b) and odd parity (dut_c), 2 stop bits, 4 clk/bit
        en[1] = 1'b1; dat[1] = 8'h07;
        en[2] = 1'b1; dat[2] = 8'h07;
        tick();
        en[1] = 1'b0; dat[1] = 'x;
        en[2] = 1'b0; dat[2] = 'x;
        repeat (4) tick();
        for (int j = 0; j < 12; j++) begin
            check("t4_even_seq", 1, {7'd0, tx_o[1]}, 8'(seq_even[j]));
            check("t4_odd_seq", 2, {7'd0, tx_o[2]}, 8'(seq_odd[j]));
            repeat (4) tick();
        end
        drain("t4");

        // Reset during data bit 3 of 0xFF with three bytes still queued
        n0 = cyc + 1;
        en[1] = 1'b1;
        dat[1] = 8'hFF; tick();
        dat[1] = 8'h01; tick();
        dat[1] = 8'h02; tick();
        dat[1] = 8'h03; tick();
        en[1] = 1'b0; dat[1] = 'x;
        while (cyc < n0 + 19) tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        check("t5_tx_after_reset", 1, {7'd0, tx_o[1]}, 8'd1);
        check("t5_empty_after_reset", 1, {7'd0, empty_o[1]}, 8'd1);
        check("t5_busy_after_reset", 1, {7'd0, busy_o[1]}, 8'd0);
        check("t5_overflow_after_reset", 1, {7'd0, ovf_o[1]}, 8'd0);
        repeat (60) tick();

        // Random writes against the model, with occasional resets on the small FIFO
        for (int i = 0; i < 400; i++) begin
            en[1]  = 1'($urandom_range(0, 1));
            dat[1] = en[1] ? 8'($urandom) : 'x;
            en[2]  = ($urandom_range(0, 3) != 0);
            dat[2] = en[2] ? 8'($urandom) : 'x;
            rst[2] = ($urandom_range(0, 199) == 0);
            tick();
        end
        en[1] = 1'b0; dat[1] = 'x;
        en[2] = 1'b0; dat[2] = 'x;
        rst[2] = 1'b0;
        drain("rand");

        // Loopback bytes into the bench receiver
        en[0] = 1'b1;
        dat[0] = 8'h00; tick();
        dat[0] = 8'hFF; tick();
        dat[0] = 8'h5A; tick();
        en[0] = 1'b0; dat[0] = 'x;
        drain("t6");
        repeat (A_CPB) tick();

        check("rx_count", 0, 8'(rxq.size()), 8'd6);
        for (int i = 0; i < 6; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            check("rx_byte", 0, got, exp_rx[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
